marquee_collector: RTL

MARQUEE_COLLECTOR -- requirements
Module: marquee_collector

---
 rtl/marquee_pkg.sv | 29 ++
 rtl/marquee_fifo.sv | 49 ++++
 rtl/marquee_collector.sv | 88 ++++++++
 3 files changed

// File: rtl/marquee_pkg.sv
// Shared constants and helpers for the marquee result collector.
// Each frame is four samples (OR, AND, XOR, CAT); CAT carries the operands.
package marquee_pkg;

    localparam logic [1:0] PH_OR  = 2'd0;
    localparam logic [1:0] PH_AND = 2'd1;
    localparam logic [1:0] PH_XOR = 2'd2;
    localparam logic [1:0] PH_CAT = 2'd3;

    localparam int FRAME_W = 7;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       err;
    } frame_t;

    // All six bits are compared, so a stray upper bit marks the frame bad.
    function automatic logic frame_err(input logic [5:0] s_or,
                                       input logic [5:0] s_and,
                                       input logic [5:0] s_xor,
                                       input logic [2:0] a,
                                       input logic [2:0] b);
        return (s_or  != {3'b000, a | b}) ||
               (s_and != {3'b000, a & b}) ||
               (s_xor != {3'b000, a ^ b});
    endfunction

endpackage

// File: rtl/marquee_fifo.sv
// Small synchronous FIFO with registered write and head-of-queue read.
// A push into a full FIFO is accepted only when a pop frees the slot that same cycle.
module marquee_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/marquee_collector.sv
// Reassembles OR/AND/XOR/CAT sample groups into checked {A,B,err} frames.
// Completed frames queue in a FIFO; frames arriving to a full queue are counted as drops.
module marquee_collector
    import marquee_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       in_data,
    input  logic             in_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_a,
    output logic [2:0]       out_b,
    output logic             out_err,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [1:0] phase;
    logic [5:0] s_or;
    logic [5:0] s_and;
    logic [5:0] s_xor;

    logic   complete;
    logic   pop;
    logic   fifo_full;
    logic   fifo_empty;
    logic   drop;
    frame_t new_frame;
    frame_t head_frame;

    assign complete      = in_valid && (phase == PH_CAT);
    assign new_frame.a   = in_data[5:3];
    assign new_frame.b   = in_data[2:0];
    assign new_frame.err = frame_err(s_or, s_and, s_xor, in_data[5:3], in_data[2:0]);

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign drop      = complete && fifo_full && !pop;

    marquee_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (complete),
        .push_data (new_frame),
        .pop       (pop),
        .head      (head_frame),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Zero the outputs while empty so the FIFO storage needs no reset.
    assign out_a   = out_valid ? head_frame.a   : 3'b000;
    assign out_b   = out_valid ? head_frame.b   : 3'b000;
    assign out_err = out_valid ? head_frame.err : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= PH_OR;
            s_or     <= '0;
            s_and    <= '0;
            s_xor    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (in_valid) begin
                phase <= phase + 2'd1;
                case (phase)
                    PH_OR:   s_or  <= in_data;
                    PH_AND:  s_and <= in_data;
                    PH_XOR:  s_xor <= in_data;
                    default: ;
                endcase
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule
